socket_wr_arbiter: RTL and testbench
====================================

Name: socket_wr_arbiter

Overview:
Frame-level round-robin arbiter that lets N_REQ producer tasks share the write port of one socket FIFO.
- A requester is granted the port for exactly FRAME_LEN words, so frames from different producers never interleave inside the socket.
- A new frame starts only when the socket reports empty, so a granted frame always fits when FRAME_LEN <= socket depth.
- Sits between several source/processing mods and the socket that feeds the next task stage.

Parameters:
DATA_WIDTH, 16, width of one data word
N_REQ, 2, number of requesters (>= 2)
FRAME_LEN, 5, words per frame; set equal to the socket DEPTH

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_req  input  N_REQ  bit k: requester k has a frame ready
i_data  input  N_REQ*DATA_WIDTH  requester k word at [k*DATA_WIDTH +: DATA_WIDTH]
i_dv  input  N_REQ  bit k: requester k word valid this cycle
i_full  input  1  socket full flag
i_empty  input  1  socket empty flag
o_grant  output  N_REQ  one-hot grant; all-zero when idle
o_data  output  DATA_WIDTH  word to socket i_data
o_wr_en  output  1  socket write enable
o_cur_id  output  $clog2(N_REQ)  index of the granted requester; valid while o_busy
o_busy  output  1  a frame transfer is in progress
o_frame_done  output  1  one-cycle pulse when the last word of a frame is written
o_overflow  output  1  sticky error flag

Behaviour:
- One clock, i_clk. Reset is synchronous, active-high, on i_rst. All outputs are registered.
- Reset values:
  - o_grant=0, o_data=0, o_wr_en=0, o_cur_id=0, o_busy=0, o_frame_done=0, o_overflow=0.
  - FSM=IDLE, beat_cnt=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, XFER.
- IDLE:
  - If |i_req and i_empty at edge t, select the first requester with i_req set, searching upward from (last+1) mod N_REQ and wrapping.
  - At t+1: o_grant=onehot(sel), o_cur_id=sel, o_busy=1, last=sel, beat_cnt=0, state -> XFER.
  - If i_empty=0, stay in IDLE regardless of i_req.
- XFER:
  - Only i_dv[o_cur_id] is honoured; i_dv and i_data from other requesters are ignored.
  - When i_dv[cur] is high at edge u: next cycle o_data=i_data[cur], o_wr_en=1, beat_cnt+1. Write latency is 1 cycle.
  - Otherwise next cycle o_wr_en=0 and o_data holds its previous value.
  - Gaps in i_dv are allowed; there is no timeout.
  - i_req[cur] dropping mid-frame is ignored. The frame completes only after FRAME_LEN honoured beats.
- Frame end: the beat that brings beat_cnt to FRAME_LEN, sampled at edge u, produces at u+1:
  - o_wr_en=1, o_frame_done=1, o_grant=0, o_busy=0, state=IDLE.
  - The earliest next grant is u+2, and only if i_empty=1.
- Overflow: a honoured beat arriving while i_full=1:
  - o_wr_en stays 0 and the word is dropped.
  - The beat still counts toward FRAME_LEN.
  - o_overflow=1 and stays set until i_rst.
- Simultaneous requests: strict round robin. After requester k's frame, priority order is k+1, ..., N_REQ-1, 0, ..., k.
- A requester raising i_req during another requester's XFER waits. No preemption.
- i_rst during XFER: the next cycle shows all reset values. The partial frame is abandoned and already-written words stay in the socket; clearing the socket is the system's job.
- beat_cnt width: $clog2(FRAME_LEN+1). No wrap-around occurs within a frame.

Test Plan:
- Reset, then i_req=2'b01, i_empty=1, i_dv[0] high for 5 cycles, data 1..5:
  - o_grant=01 one cycle after the request.
  - o_wr_en high 5 cycles with o_data 1,2,3,4,5.
  - o_frame_done pulses with word 5; o_grant=00 the same cycle.
- Both requesters continuously requesting with i_empty=1 and data=k*16+n:
  - Grants alternate 0,1,0,1.
  - Each frame is 5 contiguous-by-id words with no interleaving; o_cur_id matches the grant.
- Requester 0 granted; its i_dv toggles every other cycle while i_dv[1] is held high with data 0xBEEF:
  - Exactly 5 writes, all from requester 0, and no 0xBEEF ever appears on o_data.
  - The frame takes 10 cycles.
- i_req=01 with i_empty=0 for 10 cycles, then i_empty=1:
  - o_grant stays 0 for all 10 cycles.
  - The grant asserts one cycle after i_empty rises.
- Granted requester sends beat 3 while i_full=1:
  - No o_wr_en on that beat, o_overflow=1.
  - o_frame_done still pulses after 5 honoured beats; o_overflow stays 1 until i_rst.
- Assert i_rst after beat 2 of a frame:
  - Next cycle all outputs are at reset values.
  - A subsequent simultaneous request 2'b11 is granted to requester 0 first.

Source files
------------

// File: rtl/socket_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : socket_wr_arbiter
// Brief   : Frame-level round-robin arbiter sharing one socket FIFO write port.
// Revision: 1.0
// ============================================================================
module socket_wr_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int N_REQ      = 2,
    parameter int FRAME_LEN  = 5
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_data,
    input  logic [N_REQ-1:0]              i_dv,
    input  logic                          i_full,
    input  logic                          i_empty,
    output logic [N_REQ-1:0]              o_grant,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_wr_en,
    output logic [$clog2(N_REQ)-1:0]      o_cur_id,
    output logic                          o_busy,
    output logic                          o_frame_done,
    output logic                          o_overflow
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ID_W-1:0]       r_last, w_last_nxt;
    logic [CNT_W-1:0]      r_beat_cnt, w_cnt_nxt, w_cnt_inc;
    logic [N_REQ-1:0]      r_grant, w_grant_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt, w_data_cur;
    logic                  r_wr_en, w_wr_nxt;
    logic [ID_W-1:0]       r_cur_id, w_cur_nxt, w_sel;
    logic                  r_busy, w_busy_nxt;
    logic                  r_frame_done, w_done_nxt;
    logic                  r_overflow, w_ovf_nxt;
    logic                  w_dv_cur;
    int                    w_idx;

    // Round-robin search: descending loop so the closest requester after r_last wins.
    always_comb begin
        w_sel = r_last;
        w_idx = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_idx = (int'(r_last) + i) % N_REQ;
            if (i_req[ID_W'(w_idx)]) begin
                w_sel = ID_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_data_cur = '0;
        w_dv_cur   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_cur_id == ID_W'(k)) begin
                w_data_cur = i_data[k*DATA_WIDTH +: DATA_WIDTH];
                w_dv_cur   = i_dv[k];
            end
        end
    end

    assign w_cnt_inc = r_beat_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_beat_cnt;
        w_grant_nxt = r_grant;
        w_data_nxt  = r_data;
        w_wr_nxt    = 1'b0;
        w_cur_nxt   = r_cur_id;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_ovf_nxt   = r_overflow;
        case (r_state)
            ST_IDLE: begin
                if ((|i_req) && i_empty) begin
                    w_grant_nxt = '0;
                    w_grant_nxt[w_sel] = 1'b1;
                    w_cur_nxt   = w_sel;
                    w_last_nxt  = w_sel;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_dv_cur) begin
                    w_cnt_nxt = w_cnt_inc;
                    // A beat hitting a full socket is dropped but still counted.
                    if (i_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_wr_nxt   = 1'b1;
                        w_data_nxt = w_data_cur;
                    end
                    if (w_cnt_inc == CNT_W'(FRAME_LEN)) begin
                        w_done_nxt  = 1'b1;
                        w_grant_nxt = '0;
                        w_busy_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last       <= ID_W'(N_REQ - 1);
            r_beat_cnt   <= '0;
            r_grant      <= '0;
            r_data       <= '0;
            r_wr_en      <= 1'b0;
            r_cur_id     <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_beat_cnt   <= w_cnt_nxt;
            r_grant      <= w_grant_nxt;
            r_data       <= w_data_nxt;
            r_wr_en      <= w_wr_nxt;
            r_cur_id     <= w_cur_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_done_nxt;
            r_overflow   <= w_ovf_nxt;
        end
    end

    assign o_grant      = r_grant;
    assign o_data       = r_data;
    assign o_wr_en      = r_wr_en;
    assign o_cur_id     = r_cur_id;
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;
    assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_socket_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_socket_wr_arbiter
// Brief   : Self-checking bench for socket_wr_arbiter (vector table + scoreboard).
// Revision: 1.0
// ============================================================================
module tb_socket_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, dv;
    logic [15:0] d0, d1;
    logic        empty, full;
    logic [1:0]  grant;
    logic [15:0] odata;
    logic        wr, cur_id, busy, done, ovf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    socket_wr_arbiter #(.DATA_WIDTH(16), .N_REQ(2), .FRAME_LEN(5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_data       ({d1, d0}),
        .i_dv         (dv),
        .i_full       (full),
        .i_empty      (empty),
        .o_grant      (grant),
        .o_data       (odata),
        .o_wr_en      (wr),
        .o_cur_id     (cur_id),
        .o_busy       (busy),
        .o_frame_done (done),
        .o_overflow   (ovf)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  req, dv;
        logic [15:0] d0, d1;
        logic        empty, full;
        logic [1:0]  g;
        logic        wr;
        logic [15:0] data;
        logic        done, busy, ovf, id;
    } vec_t;

    typedef struct packed {
        logic [1:0]  g;
        logic        wr;
        logic [15:0] d;
        logic        done;
        logic        busy;
        logic        id;
    } sb_t;

    vec_t vt[23];
    sb_t  sq[$];

    function automatic vec_t v(logic r, logic [1:0] q, logic [1:0] vv, logic [15:0] a0,
                               logic [15:0] a1, logic e, logic f, logic [1:0] g, logic w,
                               logic [15:0] d, logic dn, logic b, logic ov, logic id);
        vec_t x;
        x.rst = r; x.req = q; x.dv = vv; x.d0 = a0; x.d1 = a1; x.empty = e; x.full = f;
        x.g = g; x.wr = w; x.data = d; x.done = dn; x.busy = b; x.ovf = ov; x.id = id;
        return x;
    endfunction

    // cur_id is only meaningful while busy, so it is masked otherwise.
    function automatic logic [63:0] pk(logic [1:0] g, logic w, logic [15:0] d, logic dn,
                                       logic b, logic ov, logic id);
        return {41'd0, g, w, d, dn, b, ov, (b ? id : 1'b0)};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic r, input logic [1:0] q, input logic [1:0] vv,
                         input logic [15:0] a0, input logic [15:0] a1, input logic e,
                         input logic f);
        rst = r; req = q; dv = vv; d0 = a0; d1 = a1; empty = e; full = f;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
    endtask

    task automatic observe(input string nm);
        sb_t e;
        if (sq.size() == 0) begin
            check({nm, "_sb_empty"}, 64'(sq.size()), 64'd1);
        end else begin
            e = sq.pop_front();
            check(nm, pk(grant, wr, odata, done, busy, ovf, cur_id),
                  pk(e.g, e.wr, e.d, e.done, e.busy, 1'b0, e.id));
        end
    endtask

    initial begin
        logic [15:0] last_d;
        int          beats;
        logic        in_frame;
        logic        any_grant;

        // rst  req    dv     d0      d1       emp full  grant wr  data    done busy ovf id
        vt[0]  = v(1, 2'b00, 2'b00, 16'h0,  16'h0,    1, 0, 2'b00, 0, 16'h0,  0, 0, 0, 0);
        vt[1]  = v(0, 2'b01, 2'b00, 16'h0,  16'h0,    1, 0, 2'b01, 0, 16'h0,  0, 1, 0, 0);
        vt[2]  = v(0, 2'b01, 2'b01, 16'h1,  16'h0,    1, 0, 2'b01, 1, 16'h1,  0, 1, 0, 0);
        vt[3]  = v(0, 2'b01, 2'b01, 16'h2,  16'h0,    1, 0, 2'b01, 1, 16'h2,  0, 1, 0, 0);
        vt[4]  = v(0, 2'b01, 2'b01, 16'h3,  16'h0,    1, 0, 2'b01, 1, 16'h3,  0, 1, 0, 0);
        vt[5]  = v(0, 2'b01, 2'b01, 16'h4,  16'h0,    1, 0, 2'b01, 1, 16'h4,  0, 1, 0, 0);
        vt[6]  = v(0, 2'b01, 2'b01, 16'h5,  16'h0,    1, 0, 2'b00, 1, 16'h5,  1, 0, 0, 0);
        vt[7]  = v(0, 2'b00, 2'b00, 16'h0,  16'h0,    1, 0, 2'b00, 0, 16'h5,  0, 0, 0, 0);
        vt[8]  = v(0, 2'b01, 2'b00, 16'h0,  16'h0,    1, 0, 2'b01, 0, 16'h5,  0, 1, 0, 0);
        vt[9]  = v(0, 2'b00, 2'b01, 16'h11, 16'h0,    1, 0, 2'b01, 1, 16'h11, 0, 1, 0, 0);
        vt[10] = v(0, 2'b00, 2'b01, 16'h12, 16'h0,    1, 0, 2'b01, 1, 16'h12, 0, 1, 0, 0);
        vt[11] = v(0, 2'b00, 2'b01, 16'h13, 16'h0,    1, 1, 2'b01, 0, 16'h12, 0, 1, 1, 0);
        vt[12] = v(0, 2'b00, 2'b01, 16'h14, 16'h0,    1, 0, 2'b01, 1, 16'h14, 0, 1, 1, 0);
        vt[13] = v(0, 2'b00, 2'b01, 16'h15, 16'h0,    1, 0, 2'b00, 1, 16'h15, 1, 0, 1, 0);
        vt[14] = v(0, 2'b00, 2'b00, 16'h0,  16'h0,    1, 0, 2'b00, 0, 16'h15, 0, 0, 1, 0);
        vt[15] = v(0, 2'b00, 2'b00, 16'h0,  16'h0,    1, 0, 2'b00, 0, 16'h15, 0, 0, 1, 0);
        vt[16] = v(0, 2'b01, 2'b00, 16'h0,  16'h0,    1, 0, 2'b01, 0, 16'h15, 0, 1, 1, 0);
        vt[17] = v(0, 2'b00, 2'b01, 16'h21, 16'h0,    1, 0, 2'b01, 1, 16'h21, 0, 1, 1, 0);
        vt[18] = v(0, 2'b00, 2'b01, 16'h22, 16'h0,    1, 0, 2'b01, 1, 16'h22, 0, 1, 1, 0);
        vt[19] = v(1, 2'b00, 2'b01, 16'h23, 16'h0,    1, 0, 2'b00, 0, 16'h0,  0, 0, 0, 0);
        vt[20] = v(0, 2'b11, 2'b00, 16'h0,  16'h0,    1, 0, 2'b01, 0, 16'h0,  0, 1, 0, 0);
        vt[21] = v(0, 2'b00, 2'b10, 16'h0,  16'hBEEF, 1, 0, 2'b01, 0, 16'h0,  0, 1, 0, 0);
        vt[22] = v(1, 2'b00, 2'b00, 16'h0,  16'h0,    1, 0, 2'b00, 0, 16'h0,  0, 0, 0, 0);

        drive(1'b1, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 23; i++) begin
            drive(vt[i].rst, vt[i].req, vt[i].dv, vt[i].d0, vt[i].d1, vt[i].empty, vt[i].full);
            step();
            check($sformatf("vec%0d", i), pk(grant, wr, odata, done, busy, ovf, cur_id),
                  pk(vt[i].g, vt[i].wr, vt[i].data, vt[i].done, vt[i].busy, vt[i].ovf, vt[i].id));
        end

        // Socket not empty: the request must wait until empty rises.
        do_reset();
        any_grant = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 2'b01, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
            step();
            if (grant != 2'b00) any_grant = 1'b1;
        end
        check("grant_while_not_empty", 64'(any_grant), 64'd0);
        drive(1'b0, 2'b01, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        check("grant_after_empty", 64'(grant), 64'd1);

        // Both requesting continuously: frames alternate 0,1,0,1.
        do_reset();
        last_d = 16'h0;
        for (int c = 0; c < 24; c++) begin
            int   f;
            int   ph;
            logic own;
            f   = c / 6;
            ph  = c % 6;
            own = ((f % 2) == 1);
            drive(1'b0, 2'b11, 2'b11, 16'((f << 8) | ph), 16'((f << 8) | (16 + ph)), 1'b1, 1'b0);
            if (ph == 0) begin
                sq.push_back('{g: (own ? 2'b10 : 2'b01), wr: 1'b0, d: last_d,
                               done: 1'b0, busy: 1'b1, id: own});
            end else begin
                last_d = 16'((f << 8) | (int'(own) * 16 + ph));
                sq.push_back('{g: ((ph == 5) ? 2'b00 : (own ? 2'b10 : 2'b01)), wr: 1'b1,
                               d: last_d, done: (ph == 5), busy: (ph != 5), id: own});
            end
            step();
            observe($sformatf("rr_cyc%0d", c));
        end
        drive(1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
        sq.push_back('{g: 2'b00, wr: 1'b0, d: last_d, done: 1'b0, busy: 1'b0, id: 1'b0});
        step();
        observe("rr_tail");

        // Gappy i_dv from requester 0 while requester 1 streams 0xBEEF.
        do_reset();
        last_d = 16'h0;
        beats  = 0;
        drive(1'b0, 2'b01, 2'b00, 16'h0, 16'hBEEF, 1'b1, 1'b0);
        sq.push_back('{g: 2'b01, wr: 1'b0, d: 16'h0, done: 1'b0, busy: 1'b1, id: 1'b0});
        in_frame = 1'b1;
        step();
        observe("gap_grant");
        for (int c = 1; c < 14; c++) begin
            logic dv0;
            logic fin;
            dv0 = ((c % 2) == 1) && (beats < 5);
            fin = 1'b0;
            if (dv0) begin
                beats++;
                last_d = 16'(16'h300 + beats);
                fin = (beats == 5);
            end
            drive(1'b0, 2'b00, {1'b1, dv0}, dv0 ? last_d : 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
            if (fin) in_frame = 1'b0;
            sq.push_back('{g: (in_frame ? 2'b01 : 2'b00), wr: dv0, d: last_d,
                           done: fin, busy: in_frame, id: 1'b0});
            step();
            observe($sformatf("gap_cyc%0d", c));
        end
        check("sb_drained", 64'(sq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
